id_ex_stage: RTL and testbench

ID/EX pipeline register of the 5-stage MIPS pipeline, with integrated load-use hazard detection. Captures decoded operands and control from ID and presents the *_EX signals (rs_EX, rt_EX, ALUSrcA_EX, ALUSrcB_EX, operands, Rw, RegWrite) consumed by the EX-stage ALU forwarding unit and ALU. Generates the IF/ID stall and inserts bubbles on a load-use hazard or a branch/jump flush.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths, ALU operation encodings and register constants
// used by the pipeline stages.
package mips_pkg;
    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: stall when the load in EX writes a register the
// ID instruction reads. A flush of the ID instruction overrides the stall.
module load_use_detect
    import mips_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          en,
    input  logic          MemRead_EX,
    input  logic          Valid_EX,
    input  logic [RW-1:0] Rw_EX,
    input  logic [RW-1:0] rs_ID,
    input  logic [RW-1:0] rt_ID,
    input  logic          UseRt_ID,
    input  logic          Flush,
    output logic          Stall
);
    logic hazard;

    // $0 is hard-wired, so a load targeting it never creates a dependency
    assign hazard = MemRead_EX & Valid_EX & (Rw_EX != RW'(REG_ZERO)) &
                    ((Rw_EX == rs_ID) | (UseRt_ID & (Rw_EX == rt_ID)));

    assign Stall = en & hazard & ~Flush;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation; a stall or flush
// loads a bubble into EX while the ID instruction is held upstream.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   rs_ID,
    input  logic [REG_W-1:0]   rt_ID,
    input  logic               UseRt_ID,
    input  logic [REG_W-1:0]   Rw_ID,
    input  logic               RegWrite_ID,
    input  logic               MemRead_ID,
    input  logic               MemWrite_ID,
    input  logic               MemToReg_ID,
    input  logic               ALUSrcA_ID,
    input  logic               ALUSrcB_ID,
    input  logic [ALUOP_W-1:0] ALUOp_ID,
    input  logic [DATA_W-1:0]  dataA_ID,
    input  logic [DATA_W-1:0]  dataB_ID,
    input  logic [DATA_W-1:0]  Imm_ID,
    input  logic [4:0]         Shamt_ID,
    input  logic [DATA_W-1:0]  PC_ID,
    input  logic               Flush,
    output logic [REG_W-1:0]   rs_EX,
    output logic [REG_W-1:0]   rt_EX,
    output logic [REG_W-1:0]   Rw_EX,
    output logic               RegWrite_EX,
    output logic               MemRead_EX,
    output logic               MemWrite_EX,
    output logic               MemToReg_EX,
    output logic               ALUSrcA_EX,
    output logic               ALUSrcB_EX,
    output logic [ALUOP_W-1:0] ALUOp_EX,
    output logic [DATA_W-1:0]  dataA_EX,
    output logic [DATA_W-1:0]  dataB_EX,
    output logic [DATA_W-1:0]  Imm_EX,
    output logic [DATA_W-1:0]  PC_EX,
    output logic [4:0]         Shamt_EX,
    output logic               Valid_EX,
    output logic               Stall,
    output logic [31:0]        StallCount
);
    logic bubble;

    load_use_detect #(.RW(REG_W)) u_detect (
        .en        (reset),
        .MemRead_EX(MemRead_EX),
        .Valid_EX  (Valid_EX),
        .Rw_EX     (Rw_EX),
        .rs_ID     (rs_ID),
        .rt_ID     (rt_ID),
        .UseRt_ID  (UseRt_ID),
        .Flush     (Flush),
        .Stall     (Stall)
    );

    assign bubble = Flush | Stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_EX       <= '0;
            rt_EX       <= '0;
            Rw_EX       <= '0;
            RegWrite_EX <= 1'b0;
            MemRead_EX  <= 1'b0;
            MemWrite_EX <= 1'b0;
            MemToReg_EX <= 1'b0;
            ALUSrcA_EX  <= 1'b0;
            ALUSrcB_EX  <= 1'b0;
            ALUOp_EX    <= '0;
            dataA_EX    <= '0;
            dataB_EX    <= '0;
            Imm_EX      <= '0;
            PC_EX       <= '0;
            Shamt_EX    <= '0;
            Valid_EX    <= 1'b0;
        end else if (bubble) begin
            rs_EX       <= '0;
            rt_EX       <= '0;
            Rw_EX       <= '0;
            RegWrite_EX <= 1'b0;
            MemRead_EX  <= 1'b0;
            MemWrite_EX <= 1'b0;
            MemToReg_EX <= 1'b0;
            ALUSrcA_EX  <= 1'b0;
            ALUSrcB_EX  <= 1'b0;
            ALUOp_EX    <= '0;
            dataA_EX    <= '0;
            dataB_EX    <= '0;
            Imm_EX      <= '0;
            PC_EX       <= '0;
            Shamt_EX    <= '0;
            Valid_EX    <= 1'b0;
        end else begin
            rs_EX       <= rs_ID;
            rt_EX       <= rt_ID;
            Rw_EX       <= Rw_ID;
            RegWrite_EX <= RegWrite_ID;
            MemRead_EX  <= MemRead_ID;
            MemWrite_EX <= MemWrite_ID;
            MemToReg_EX <= MemToReg_ID;
            ALUSrcA_EX  <= ALUSrcA_ID;
            ALUSrcB_EX  <= ALUSrcB_ID;
            ALUOp_EX    <= ALUOp_ID;
            dataA_EX    <= dataA_ID;
            dataB_EX    <= dataB_ID;
            Imm_EX      <= Imm_ID;
            PC_EX       <= PC_ID;
            Shamt_EX    <= Shamt_ID;
            Valid_EX    <= 1'b1;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            StallCount <= '0;
        else if (Stall && StallCount != 32'hFFFF_FFFF)
            StallCount <= StallCount + 32'd1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against an instruction-level
// model of what EX holds and how many load-use stalls have occurred.
module tb_id_ex_stage;
    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rw;
        logic        usert, rwr, mr, mw, m2r, asa, asb;
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc;
        logic [4:0]  sh;
        logic        flush;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0]  rs_ID, rt_ID, Rw_ID, Shamt_ID;
    logic        UseRt_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID;
    logic        ALUSrcA_ID, ALUSrcB_ID, Flush;
    logic [3:0]  ALUOp_ID;
    logic [31:0] dataA_ID, dataB_ID, Imm_ID, PC_ID;
    logic [4:0]  rs_EX, rt_EX, Rw_EX, Shamt_EX;
    logic        RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX;
    logic        ALUSrcA_EX, ALUSrcB_EX, Valid_EX, Stall;
    logic [3:0]  ALUOp_EX;
    logic [31:0] dataA_EX, dataB_EX, Imm_EX, PC_EX, StallCount;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .UseRt_ID(UseRt_ID), .Rw_ID(Rw_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .MemToReg_ID(MemToReg_ID), .ALUSrcA_ID(ALUSrcA_ID), .ALUSrcB_ID(ALUSrcB_ID),
        .ALUOp_ID(ALUOp_ID), .dataA_ID(dataA_ID), .dataB_ID(dataB_ID), .Imm_ID(Imm_ID),
        .Shamt_ID(Shamt_ID), .PC_ID(PC_ID), .Flush(Flush),
        .rs_EX(rs_EX), .rt_EX(rt_EX), .Rw_EX(Rw_EX), .RegWrite_EX(RegWrite_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .MemToReg_EX(MemToReg_EX),
        .ALUSrcA_EX(ALUSrcA_EX), .ALUSrcB_EX(ALUSrcB_EX), .ALUOp_EX(ALUOp_EX),
        .dataA_EX(dataA_EX), .dataB_EX(dataB_EX), .Imm_EX(Imm_EX), .PC_EX(PC_EX),
        .Shamt_EX(Shamt_EX), .Valid_EX(Valid_EX), .Stall(Stall), .StallCount(StallCount)
    );

    int n_chk = 0;
    int n_pass = 0;
    instr_t ex_m;            // what EX should hold (valid=0 means bubble)
    longint unsigned stalls; // stall cycles seen by the model

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic instr_t bubble_i();
        instr_t b;
        b = '{valid:0, rs:0, rt:0, rw:0, usert:0, rwr:0, mr:0, mw:0, m2r:0, asa:0, asb:0,
              op:0, a:0, b:0, imm:0, pc:0, sh:0, flush:0};
        return b;
    endfunction

    function automatic instr_t rand_i();
        instr_t r;
        r.valid = 1'b1;
        r.rs = 5'($urandom_range(0, 31));
        r.rt = 5'($urandom_range(0, 31));
        r.rw = 5'($urandom_range(0, 31));
        // bias sources toward the register the EX load writes
        if ($urandom_range(0, 2) == 0) r.rs = ex_m.rw;
        if ($urandom_range(0, 2) == 0) r.rt = ex_m.rw;
        r.usert = 1'($urandom_range(0, 1));
        r.rwr = 1'($urandom_range(0, 1));
        r.mr  = ($urandom_range(0, 1) == 0);
        r.mw  = 1'($urandom_range(0, 1));
        r.m2r = 1'($urandom_range(0, 1));
        r.asa = 1'($urandom_range(0, 1));
        r.asb = 1'($urandom_range(0, 1));
        r.op  = 4'($urandom_range(0, 15));
        r.a = $urandom(); r.b = $urandom(); r.imm = $urandom(); r.pc = $urandom();
        r.sh = 5'($urandom_range(0, 31));
        r.flush = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    function automatic instr_t op_i(input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic usert, input logic [4:0] rw);
        instr_t r;
        r = rand_i();
        r.mr = mr; r.rs = rs; r.rt = rt; r.usert = usert; r.rw = rw;
        r.rwr = 1'b1; r.flush = 1'b0;
        return r;
    endfunction

    task automatic drive(input instr_t i);
        rs_ID = i.rs; rt_ID = i.rt; Rw_ID = i.rw; UseRt_ID = i.usert;
        RegWrite_ID = i.rwr; MemRead_ID = i.mr; MemWrite_ID = i.mw; MemToReg_ID = i.m2r;
        ALUSrcA_ID = i.asa; ALUSrcB_ID = i.asb; ALUOp_ID = i.op;
        dataA_ID = i.a; dataB_ID = i.b; Imm_ID = i.imm; PC_ID = i.pc; Shamt_ID = i.sh;
        Flush = i.flush;
    endtask

    // A dependent instruction must wait while a real load to a nonzero reg sits in EX
    function automatic bit must_stall(input instr_t id);
        bit dep;
        dep = (id.rs == ex_m.rw) || (id.usert && id.rt == ex_m.rw);
        return ex_m.valid && ex_m.mr && ex_m.rw != 0 && dep && !id.flush;
    endfunction

    task automatic check_ex(input string tag);
        chk({tag, ".valid"}, 64'(Valid_EX), 64'(ex_m.valid));
        chk({tag, ".rs"}, 64'(rs_EX), 64'(ex_m.rs));
        chk({tag, ".rt"}, 64'(rt_EX), 64'(ex_m.rt));
        chk({tag, ".rw"}, 64'(Rw_EX), 64'(ex_m.rw));
        chk({tag, ".ctl"},
            64'({RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrcA_EX, ALUSrcB_EX}),
            64'({ex_m.rwr, ex_m.mr, ex_m.mw, ex_m.m2r, ex_m.asa, ex_m.asb}));
        chk({tag, ".op"}, 64'(ALUOp_EX), 64'(ex_m.op));
        chk({tag, ".ab"}, {dataA_EX, dataB_EX}, {ex_m.a, ex_m.b});
        chk({tag, ".imm_pc"}, {Imm_EX, PC_EX}, {ex_m.imm, ex_m.pc});
        chk({tag, ".sh"}, 64'(Shamt_EX), 64'(ex_m.sh));
        chk({tag, ".cnt"}, 64'(StallCount), 64'(stalls));
    endtask

    // Present one ID instruction, check Stall, clock, then check EX contents
    task automatic step(input string tag, input instr_t id);
        bit st;
        drive(id);
        #1;
        st = must_stall(id);
        chk({tag, ".stall"}, 64'(Stall), 64'(st));
        @(posedge clk);
        if (st || id.flush) ex_m = bubble_i();
        else ex_m = id;
        if (st && stalls != 64'hFFFF_FFFF) stalls++;
        #1;
        check_ex(tag);
    endtask

    initial begin
        ex_m = bubble_i();
        stalls = 0;
        reset = 1'b0;
        drive(rand_i());
        repeat (3) begin
            @(posedge clk);
            drive(op_i(1'b1, 5'd7, 5'd7, 1'b1, 5'd7));
        end
        #1;
        check_ex("reset");
        chk("reset.stall", 64'(Stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // pass-through
        begin
            instr_t p;
            p = op_i(1'b0, 5'd3, 5'd4, 1'b1, 5'd5);
            p.a = 32'h1234; p.op = 4'd2;
            step("pass", p);
            chk("pass.rs_const", 64'(rs_EX), 64'd3);
            chk("pass.da_const", 64'(dataA_EX), 64'h1234);
        end

        // load-use on rs: one bubble then the add enters
        step("lw8", op_i(1'b1, 5'd1, 5'd2, 1'b0, 5'd8));
        step("lu_stall", op_i(1'b0, 5'd8, 5'd2, 1'b1, 5'd10));
        chk("lu.cnt_const", 64'(StallCount), 64'd1);
        step("lu_go", op_i(1'b0, 5'd8, 5'd2, 1'b1, 5'd10));
        chk("lu.rs8", 64'(rs_EX), 64'd8);

        // rt match masked by UseRt=0
        step("lw9", op_i(1'b1, 5'd1, 5'd2, 1'b0, 5'd9));
        step("usert0", op_i(1'b0, 5'd1, 5'd9, 1'b0, 5'd11));

        // back-to-back dependent loads, each stalls once
        step("ld1", op_i(1'b1, 5'd1, 5'd2, 1'b0, 5'd12));
        step("ld2_st", op_i(1'b1, 5'd12, 5'd0, 1'b0, 5'd13));
        step("ld2_go", op_i(1'b1, 5'd12, 5'd0, 1'b0, 5'd13));
        step("use_st", op_i(1'b0, 5'd0, 5'd13, 1'b1, 5'd14));
        step("use_go", op_i(1'b0, 5'd0, 5'd13, 1'b1, 5'd14));

        // flush beats stall
        step("lw8b", op_i(1'b1, 5'd1, 5'd2, 1'b0, 5'd8));
        begin
            instr_t f;
            f = op_i(1'b0, 5'd8, 5'd8, 1'b1, 5'd3);
            f.flush = 1'b1;
            step("flush", f);
        end

        // $0 destination
        step("lw0", op_i(1'b1, 5'd1, 5'd2, 1'b0, 5'd0));
        step("zero", op_i(1'b0, 5'd0, 5'd0, 1'b1, 5'd3));

        // reset asserted while a stall is pending
        step("lw8c", op_i(1'b1, 5'd1, 5'd2, 1'b0, 5'd8));
        drive(op_i(1'b0, 5'd8, 5'd2, 1'b0, 5'd4));
        #1;
        chk("mid.stall_pre", 64'(Stall), 64'd1);
        reset = 1'b0;
        #1;
        ex_m = bubble_i();
        stalls = 0;
        chk("mid.stall_rst", 64'(Stall), 64'd0);
        check_ex("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        step("mid_rel", op_i(1'b0, 5'd8, 5'd2, 1'b0, 5'd4));

        // random traffic
        for (int k = 0; k < 400; k++) step("rnd", rand_i());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
